// File: rtl/goertzel_bin_scheduler.sv
// goertzel_bin_scheduler
// Walks the Goertzel datapath across NUM_BINS frequency bins, one bin per
// manager handshake. Holds a writable sin/cos coefficient table, presents the
// current bin's pair, tags each returned magnitude with its bin index and runs
// a per-bin threshold counter that sets a debounced detect bit after
// HOLD_FRAMES consecutive hits.
// Optional feature: define GBS_TIMEOUT_EN to add a BUSY-state watchdog that
// raises timeout_err and re-arms the same bin after TIMEOUT_CYC cycles.
module goertzel_bin_scheduler #(
  parameter int NUM_BINS    = 4,
  parameter int BIN_BITS    = 2,
  parameter int MAG_W       = 16,
  parameter int HOLD_FRAMES = 3,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                sys_clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                cfg_we,
  input  logic [BIN_BITS-1:0] cfg_addr,
  input  logic [15:0]         cfg_sin,
  input  logic [15:0]         cfg_cos,
  input  logic [MAG_W-1:0]    thresh,
  input  logic                err_clr,
  input  logic                request_trig,
  output logic [15:0]         sin_out,
  output logic [15:0]         cos_out,
  input  logic [MAG_W-1:0]    mag_in,
  input  logic                mag_rdy,
  output logic [MAG_W-1:0]    bin_mag,
  output logic [BIN_BITS-1:0] bin_idx,
  output logic                bin_valid,
  output logic                frame_done,
  output logic [NUM_BINS-1:0] detect_mask,
  output logic                orphan_err,
  output logic                timeout_err
);

  localparam int                  TAB_DEPTH = 1 << BIN_BITS;
  localparam logic [BIN_BITS-1:0] LAST_BIN  = BIN_BITS'(NUM_BINS - 1);
  localparam logic [2:0]          HOLD_VAL  = 3'(HOLD_FRAMES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_BUSY,
    S_UPDATE
  } state_t;

  state_t state;
  state_t next_state;

  logic [15:0]         sin_tab [TAB_DEPTH];
  logic [15:0]         cos_tab [TAB_DEPTH];
  logic [2:0]          hit_cnt [NUM_BINS];

  logic [BIN_BITS-1:0] cur_bin;
  logic [BIN_BITS-1:0] nxt_bin;
  logic [BIN_BITS-1:0] load_idx;
  logic [15:0]         load_sin;
  logic [15:0]         load_cos;

  logic                load_now;
  logic                capture;
  logic                advance;
  logic                orphan;
  logic                wd_expired;

  logic                hit;
  logic [2:0]          cur_cnt;
  logic [2:0]          new_cnt;

  // Next bin in scan order, wrapping after the last configured bin
  always_comb begin
    nxt_bin = cur_bin + BIN_BITS'(1);
    if (cur_bin == LAST_BIN) begin
      nxt_bin = '0;
    end
  end

  // Coefficient source for a load: table entry, or a same-cycle write to that entry
  always_comb begin
    load_idx = load_now ? cur_bin : nxt_bin;
    load_sin = sin_tab[load_idx];
    load_cos = cos_tab[load_idx];
    if (cfg_we && (cfg_addr == load_idx)) begin
      load_sin = cfg_sin;
      load_cos = cfg_cos;
    end
  end

  // Hit-counter step for the bin being retired; the captured magnitude is compared
  always_comb begin
    cur_cnt = '0;
    for (int b = 0; b < NUM_BINS; b++) begin
      if (cur_bin == BIN_BITS'(b)) begin
        cur_cnt = hit_cnt[b];
      end
    end
    hit = (bin_mag >= thresh);
    if (!hit) begin
      new_cnt = '0;
    end else if (cur_cnt == HOLD_VAL) begin
      new_cnt = cur_cnt;
    end else begin
      new_cnt = cur_cnt + 3'd1;
    end
  end

  // Coefficient table storage, writable on any cycle
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAB_DEPTH; i++) begin
        sin_tab[i] <= '0;
        cos_tab[i] <= '0;
      end
    end else if (cfg_we) begin
      sin_tab[cfg_addr] <= cfg_sin;
      cos_tab[cfg_addr] <= cfg_cos;
    end
  end

  // Scan state register
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and per-cycle control strobes; stray handshake pulses flagged
  always_comb begin
    next_state = state;
    load_now   = 1'b0;
    capture    = 1'b0;
    advance    = 1'b0;
    orphan     = 1'b0;
    case (state)
      S_IDLE: begin
        if (request_trig || mag_rdy) begin
          orphan = 1'b1;
        end
        if (enable) begin
          load_now   = 1'b1;
          next_state = S_ARMED;
        end
      end
      S_ARMED: begin
        if (mag_rdy) begin
          orphan = 1'b1;
        end
        if (request_trig) begin
          next_state = S_BUSY;
        end else if (!enable) begin
          next_state = S_IDLE;
        end
      end
      S_BUSY: begin
        if (request_trig) begin
          orphan = 1'b1;
        end
        if (mag_rdy) begin
          capture    = 1'b1;
          next_state = S_UPDATE;
        end else if (wd_expired) begin
          next_state = S_ARMED;
        end
      end
      S_UPDATE: begin
        if (request_trig || mag_rdy) begin
          orphan = 1'b1;
        end
        advance    = 1'b1;
        next_state = enable ? S_ARMED : S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Current bin pointer and the coefficient pair presented to the manager
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      cur_bin <= '0;
      sin_out <= '0;
      cos_out <= '0;
    end else begin
      if (load_now || advance) begin
        sin_out <= load_sin;
        cos_out <= load_cos;
      end
      if (advance) begin
        cur_bin <= nxt_bin;
      end
    end
  end

  // Magnitude capture with bin tag, plus the end-of-scan pulse
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      bin_mag    <= '0;
      bin_idx    <= '0;
      bin_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      bin_valid  <= capture;
      frame_done <= advance && (cur_bin == LAST_BIN);
      if (capture) begin
        bin_mag <= mag_in;
        bin_idx <= cur_bin;
      end
    end
  end

  // Per-bin consecutive-hit counters and the debounced detect mask
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NUM_BINS; b++) begin
        hit_cnt[b] <= '0;
      end
      detect_mask <= '0;
    end else if (advance) begin
      for (int b = 0; b < NUM_BINS; b++) begin
        if (cur_bin == BIN_BITS'(b)) begin
          hit_cnt[b]     <= new_cnt;
          detect_mask[b] <= (new_cnt == HOLD_VAL);
        end
      end
    end
  end

  // Sticky orphan flag; a clear beats a simultaneous set
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      orphan_err <= 1'b0;
    end else if (err_clr) begin
      orphan_err <= 1'b0;
    end else if (orphan) begin
      orphan_err <= 1'b1;
    end
  end

`ifdef GBS_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;

  logic [WD_W-1:0] wd_cnt;
  logic            wd_fire;

  assign wd_expired = (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
  assign wd_fire    = (state == S_BUSY) && !mag_rdy && wd_expired;

  // Watchdog counts consecutive BUSY cycles, restarting whenever BUSY is left
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if ((state == S_BUSY) && (next_state == S_BUSY)) begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end else begin
      wd_cnt <= '0;
    end
  end

  // Sticky timeout flag; a clear beats a simultaneous set
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      timeout_err <= 1'b0;
    end else if (err_clr) begin
      timeout_err <= 1'b0;
    end else if (wd_fire) begin
      timeout_err <= 1'b1;
    end
  end
`else
  assign wd_expired  = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule
